tx_frame_ctrl: RTL

- Frame sequencer in front of the 802.11 TX datapath (scrambler + convolutional encoder).
- Accepts one frame command (rate, length in words) and gates the payload AXI-Stream into the datapath.
- Stamps tuser with the rate and generates tlast on the final word.
- Monitors the datapath output for the frame's closing tlast, then reports done; reports error on a zero-length command or a drain timeout.

---
 rtl/tx_frame_ctrl_pkg.sv | 22 ++
 rtl/tx_beat_counter.sv | 30 +++
 rtl/tx_frame_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/tx_frame_ctrl_pkg.sv
// Shared definitions for the 802.11 TX frame sequencer: rate codes, defaults, FSM states.
package tx_frame_ctrl_pkg;

  localparam int RATE_WIDTH_DEF = 4;

  // 802.11a SIGNAL-field RATE codes
  localparam logic [3:0] RATE_6M  = 4'b1101;
  localparam logic [3:0] RATE_9M  = 4'b1111;
  localparam logic [3:0] RATE_12M = 4'b0101;
  localparam logic [3:0] RATE_18M = 4'b0111;
  localparam logic [3:0] RATE_24M = 4'b1001;
  localparam logic [3:0] RATE_36M = 4'b1011;
  localparam logic [3:0] RATE_48M = 4'b0001;
  localparam logic [3:0] RATE_54M = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_STREAM = 2'b01,
    ST_DRAIN  = 2'b10
  } state_t;

endpackage

// File: rtl/tx_beat_counter.sv
// Clearable up-counter with a terminal-value match flag; used for frame beats and drain timeout.
module tx_beat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         match
);

  logic [W-1:0] count_r;

  // Clear has priority over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (en) begin
      count_r <= count_r + W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign match = (count_r == term);

endmodule

// File: rtl/tx_frame_ctrl.sv
// Frame sequencer gating payload into the 802.11 TX datapath and watching its closing tlast.
// Optional build macro TX_FRAME_COUNT_EN adds a 16-bit count of completed frames.
module tx_frame_ctrl
  import tx_frame_ctrl_pkg::*;
#(
  parameter int WIDTH         = 24,
  parameter int LEN_WIDTH     = 12,
  parameter int RATE_WIDTH    = RATE_WIDTH_DEF,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [RATE_WIDTH+LEN_WIDTH-1:0] cmd_tdata,
  input  logic                            cmd_tvalid,
  output logic                            cmd_tready,
  input  logic [WIDTH-1:0]                s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic [WIDTH-1:0]                m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [RATE_WIDTH-1:0]           m_axis_tuser,
  input  logic                            mon_tvalid,
  input  logic                            mon_tready,
  input  logic                            mon_tlast,
  output logic                            busy,
  output logic                            done,
  output logic                            err
`ifdef TX_FRAME_COUNT_EN
  ,
  output logic [15:0]                     frame_count
`endif
);

  localparam int TO_WIDTH = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;

  state_t                state;
  logic [RATE_WIDTH-1:0] rate_r;
  logic [LEN_WIDTH-1:0]  len_r;
  logic                  armed_r;

  logic [RATE_WIDTH-1:0] cmd_rate_s;
  logic [LEN_WIDTH-1:0]  cmd_len_s;
  logic                  cmd_hs_s;
  logic                  m_hs_s;
  logic                  mon_last_s;
  logic                  beat_match_s;
  logic                  to_match_s;
  logic                  beat_clr_s;
  logic                  beat_en_s;
  logic                  to_clr_s;
  logic                  to_en_s;

  assign cmd_rate_s = cmd_tdata[RATE_WIDTH+LEN_WIDTH-1 -: RATE_WIDTH];
  assign cmd_len_s  = cmd_tdata[LEN_WIDTH-1:0];

  // armed_r keeps cmd_tready low until the first clock after reset release
  assign cmd_tready    = armed_r && (state == ST_IDLE);
  assign cmd_hs_s      = cmd_tvalid && cmd_tready;
  assign m_axis_tvalid = (state == ST_STREAM) && s_axis_tvalid;
  assign s_axis_tready = (state == ST_STREAM) && m_axis_tready;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tuser  = rate_r;
  assign m_axis_tlast  = (state == ST_STREAM) && beat_match_s;
  assign m_hs_s        = m_axis_tvalid && m_axis_tready;
  assign mon_last_s    = mon_tvalid && mon_tready && mon_tlast;
  assign busy          = (state != ST_IDLE);

  // Counter controls; the timeout counter sits at zero outside DRAIN
  always_comb begin
    beat_clr_s = 1'b0;
    beat_en_s  = 1'b0;
    to_clr_s   = 1'b1;
    to_en_s    = 1'b0;
    case (state)
      ST_IDLE: begin
        beat_clr_s = cmd_hs_s;
      end
      ST_STREAM: begin
        beat_en_s = m_hs_s;
      end
      ST_DRAIN: begin
        to_clr_s = 1'b0;
        to_en_s  = 1'b1;
      end
      default: begin
        beat_clr_s = 1'b1;
      end
    endcase
  end

  tx_beat_counter #(
    .W (LEN_WIDTH)
  ) u_beat_cnt (
    .clk   (aclk),
    .rst   (areset),
    .clr   (beat_clr_s),
    .en    (beat_en_s),
    .term  (len_r - LEN_WIDTH'(1'b1)),
    .match (beat_match_s)
  );

  tx_beat_counter #(
    .W (TO_WIDTH)
  ) u_drain_cnt (
    .clk   (aclk),
    .rst   (areset),
    .clr   (to_clr_s),
    .en    (to_en_s),
    .term  (TO_WIDTH'(DRAIN_TIMEOUT - 1)),
    .match (to_match_s)
  );

  // Frame FSM with registered done/err pulses
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state   <= ST_IDLE;
      rate_r  <= {RATE_WIDTH{1'b0}};
      len_r   <= {LEN_WIDTH{1'b0}};
      armed_r <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
`ifdef TX_FRAME_COUNT_EN
      frame_count <= 16'd0;
`endif
    end else begin
      armed_r <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_hs_s) begin
            if (cmd_len_s == {LEN_WIDTH{1'b0}}) begin
              err <= 1'b1;
            end else begin
              rate_r <= cmd_rate_s;
              len_r  <= cmd_len_s;
              state  <= ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if (m_hs_s && beat_match_s) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // A monitor tlast in the timeout cycle still counts as success
          if (mon_last_s) begin
            done  <= 1'b1;
            state <= ST_IDLE;
`ifdef TX_FRAME_COUNT_EN
            frame_count <= frame_count + 16'd1;
`endif
          end else if (to_match_s) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
